// File: rtl/sum_squares.sv
// Sums the squares of N_SAMPLES signed samples using a 1-bit/clk shift-add squarer; result saturates at 32 bits.
// Latency: 17 edges from last accept to sum_rdy, 18 cycles/sample; sample_rdy only in WAIT_S, source holds sample.
module sum_squares #(
  parameter int N_SAMPLES = 2,
  parameter int SAMPLE_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_vld,
  output logic                sample_rdy,
  output logic [31:0]         sum_out,
  output logic                sum_rdy,
  output logic                busy,
  output logic                ovf
);

  localparam int IDX_W = $clog2(SAMPLE_W);
  localparam int MAG_W = SAMPLE_W + 1;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {IDLE, WAIT_S, SQUARE, ACC, DONE} state_t;

  state_t            state, state_nx;
  logic [31:0]       acc, acc_nx;
  logic [31:0]       product, product_nx;
  logic [31:0]       mcand, mcand_nx;
  logic [MAG_W-1:0]  mplier, mplier_nx;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              ovf_nx;
  logic [31:0]       sum_out_nx;
  logic [MAG_W-1:0]  mag;
  logic [32:0]       sum33;

  // Sign-extend before negating so -32768 becomes +32768 rather than wrapping.
  always_comb begin
    mag = {1'b0, sample_in};
    if (sample_in[SAMPLE_W-1]) begin
      mag = ~{1'b1, sample_in} + MAG_W'(1);
    end
  end

  assign sum33 = {1'b0, acc} + {1'b0, product};

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    product_nx = product;
    mcand_nx   = mcand;
    mplier_nx  = mplier;
    bit_idx_nx = bit_idx;
    cnt_nx     = cnt;
    ovf_nx     = ovf;
    sum_out_nx = sum_out;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = WAIT_S;
        end
      end
      WAIT_S: begin
        if (sample_vld && sample_rdy) begin
          mcand_nx   = 32'(mag);
          mplier_nx  = mag;
          product_nx = '0;
          bit_idx_nx = '0;
          state_nx   = SQUARE;
        end
      end
      SQUARE: begin
        if (mplier[0]) begin
          product_nx = product + mcand;
        end
        mcand_nx   = mcand << 1;
        mplier_nx  = mplier >> 1;
        bit_idx_nx = bit_idx + IDX_W'(1);
        if (bit_idx == IDX_W'(SAMPLE_W - 1)) begin
          state_nx = ACC;
        end
      end
      ACC: begin
        // Once saturated, stay saturated for the rest of the frame.
        if (sum33[32] || ovf) begin
          acc_nx = '1;
          ovf_nx = 1'b1;
        end else begin
          acc_nx = sum33[31:0];
        end
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N_SAMPLES - 1)) begin
          state_nx   = DONE;
          sum_out_nx = acc_nx;
        end else begin
          state_nx = WAIT_S;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      product    <= '0;
      mcand      <= '0;
      mplier     <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      sum_out    <= '0;
      sum_rdy    <= 1'b0;
      sample_rdy <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      product    <= product_nx;
      mcand      <= mcand_nx;
      mplier     <= mplier_nx;
      bit_idx    <= bit_idx_nx;
      cnt        <= cnt_nx;
      ovf        <= ovf_nx;
      sum_out    <= sum_out_nx;
      sum_rdy    <= (state_nx == DONE);
      sample_rdy <= (state_nx == WAIT_S);
      busy       <= (state_nx == WAIT_S) || (state_nx == SQUARE) || (state_nx == ACC);
    end
  end

endmodule
